led_pattern_seq: RTL and testbench

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_pattern_seq.sv | 113 +++++++++++
 tb/tb_led_pattern_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: plays a captured PLEN-step bit pattern, one step per
// tick, for a captured number of passes, optionally gated by an upstream blink.
module led_pattern_seq #(
    parameter int PLEN  = 8,
    parameter int RBITS = 4,
    localparam int SW   = $clog2(PLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             blink_in,
    input  logic             start,
    input  logic             abort,
    input  logic [PLEN-1:0]  pattern,
    input  logic [RBITS-1:0] reps,
    input  logic             gate,
    output logic             led_out,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    step_idx
);

    typedef enum logic [1:0] {IDLE, ARM, PLAY, DONE} state_t;

    localparam logic [SW-1:0] LAST = SW'(PLEN - 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [RBITS-1:0] rep_q, rep_d;
    logic [RBITS-1:0] reps_q, reps_d;
    logic [PLEN-1:0]  pat_q, pat_d;
    logic             gate_q, gate_d;
    logic             led_q, led_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            rep_q   <= '0;
            reps_q  <= '0;
            pat_q   <= '0;
            gate_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
            reps_q  <= reps_d;
            pat_q   <= pat_d;
            gate_q  <= gate_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rep_d   = rep_q;
        reps_d  = reps_q;
        pat_d   = pat_q;
        gate_d  = gate_q;
        led_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Inputs are latched only here so a run is immune to later changes.
                if (start && !abort) begin
                    pat_d   = pattern;
                    reps_d  = reps;
                    gate_d  = gate;
                    state_d = (reps != '0) ? ARM : DONE;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = PLAY;
                    step_d  = '0;
                    rep_d   = reps_q;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                    rep_d   = '0;
                end else begin
                    led_d = pat_q[step_q] & (gate_q ? blink_in : 1'b1);
                    if (tick) begin
                        if (step_q != LAST) begin
                            step_d = step_q + SW'(1);
                        end else if (rep_q > RBITS'(1)) begin
                            step_d = '0;
                            rep_d  = rep_q - RBITS'(1);
                        end else begin
                            state_d = DONE;
                            step_d  = '0;
                            rep_d   = '0;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign led_out  = led_q;
    assign busy     = (state_q == ARM) || (state_q == PLAY);
    assign done     = (state_q == DONE);
    assign step_idx = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: scenario tasks compared each cycle against a
// tick-counting reference model of the pattern player.
module tb_led_pattern_seq;
    localparam int PLEN  = 8;
    localparam int RBITS = 4;
    localparam int SW    = $clog2(PLEN);

    logic clk = 1'b0, rst = 1'b1;
    logic tick = 0, blink_in = 0, start = 0, abort = 0, gate = 0;
    logic [PLEN-1:0] pattern = '0;
    logic [RBITS-1:0] reps = '0;
    logic led_out, busy, done;
    logic [SW-1:0] step_idx;

    int errors = 0, checks = 0;

    led_pattern_seq #(.PLEN(PLEN), .RBITS(RBITS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .blink_in(blink_in), .start(start),
        .abort(abort), .pattern(pattern), .reps(reps), .gate(gate),
        .led_out(led_out), .busy(busy), .done(done), .step_idx(step_idx));

    always #5 clk = ~clk;

    // Reference: a run is "active" from capture; m_n counts ticks seen after
    // capture. n=0 is waiting, n=1..reps*PLEN plays step (n-1)%PLEN.
    logic m_act, m_done, m_led;
    int m_n;
    logic [PLEN-1:0] m_pat;
    int m_reps;
    logic m_gate;
    logic n_act, n_done, n_led, n_gate;
    int n_n, n_reps;
    logic [PLEN-1:0] n_pat;
    logic [SW-1:0] m_step;

    always_comb begin
        n_act = m_act; n_done = 1'b0; n_n = m_n;
        n_pat = m_pat; n_reps = m_reps; n_gate = m_gate;
        n_led = 1'b0;
        if (m_act && m_n >= 1 && !abort)
            n_led = m_pat[(m_n - 1) % PLEN] & (m_gate ? blink_in : 1'b1);
        if (m_done) begin
            n_done = 1'b0;
        end else if (m_act) begin
            if (abort) n_act = 1'b0;
            else if (tick) begin
                n_n = m_n + 1;
                if (n_n > m_reps * PLEN) begin n_act = 1'b0; n_done = 1'b1; end
            end
        end else if (start && !abort) begin
            n_pat = pattern; n_reps = int'(reps); n_gate = gate;
            if (reps == 0) n_done = 1'b1;
            else begin n_act = 1'b1; n_n = 0; end
        end
        m_step = (m_act && m_n >= 1) ? SW'((m_n - 1) % PLEN) : '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 0; m_done <= 0; m_led <= 0; m_n <= 0;
            m_pat <= '0; m_reps <= 0; m_gate <= 0;
        end else begin
            m_act <= n_act; m_done <= n_done; m_led <= n_led; m_n <= n_n;
            m_pat <= n_pat; m_reps <= n_reps; m_gate <= n_gate;
        end
    end

    wire [SW+2:0] obs = {led_out, busy, done, step_idx};
    wire [SW+2:0] expv = {m_led, m_act, m_done, m_step};

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== {(SW+3){1'b0}}) begin
                errors++; $display("FAIL reset c=%0d got=%b exp=0", c, obs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int ticks = 0, dones = 0;
        pattern = 8'b1010_0110; reps = 1; gate = 0;
        for (int c = 0; c < 55; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL basic c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (done) dones++;
            start = (c == 0);
            tick = (c >= 2 && (c - 2) % 5 == 0 && ticks < 9);
            if (tick) ticks++;
            if (c > 0) begin pattern = PLEN'($urandom); reps = RBITS'($urandom); gate = $urandom; end
        end
        tick = 0;
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_zero_reps();
        int dones = 0, busy_seen = 0;
        reps = 0; pattern = 8'hFF; gate = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL zero_reps c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (done) dones++;
            if (busy || led_out) busy_seen++;
            start = (c == 0);
        end
        checks++;
        if (dones !== 1 || busy_seen !== 0) begin
            errors++; $display("FAIL zero_reps_pulse got done=%0d busy/led=%0d exp 1/0", dones, busy_seen);
        end
    endtask

    task automatic test_wrap();
        int ticks = 0, at_done = -1, wraps = 0;
        logic [SW-1:0] prev = '0;
        reps = 3; pattern = 8'hFF; gate = 0;
        for (int c = 0; c < 62; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL wrap c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (busy && prev == SW'(PLEN - 1) && step_idx == '0) wraps++;
            prev = step_idx;
            if (done && at_done < 0) at_done = ticks;
            start = (c == 0);
            // The tick coinciding with the capture must not count.
            tick = (c == 0) || (c >= 2 && c % 2 == 0);
            if (tick && c > 0) ticks++;
        end
        tick = 0;
        checks++;
        if (at_done !== 25) begin errors++; $display("FAIL wrap_ticks got=%0d exp=25", at_done); end
        checks++;
        if (wraps !== 2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", wraps); end
    endtask

    task automatic test_gate();
        reps = 1; pattern = 8'hFF; gate = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL gate c=%0d got=%b exp=%b", c, obs, expv);
            end
            start = (c == 0);
            if (c == 1) gate = 0;
            tick = (c >= 2 && c % 3 == 0);
            blink_in = $urandom;
        end
        tick = 0; blink_in = 0;
    endtask

    task automatic test_abort();
        int dones = 0, hit = -1;
        reps = 2; pattern = PLEN'($urandom); gate = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL abort c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (done) dones++;
            if (hit >= 0 && c == hit + 1) begin
                checks++;
                if ({busy, led_out, done} !== 3'b000) begin
                    errors++; $display("FAIL abort_idle got=%b exp=000", {busy, led_out, done});
                end
            end
            start = (c == 0);
            abort = 1'b0;
            if (hit < 0 && busy && step_idx == SW'(4)) begin
                hit = c; abort = 1'b1; start = 1'b1;
            end
            tick = (c >= 2 && c % 2 == 0);
        end
        tick = 0; start = 0; abort = 0;
        checks++;
        if (dones !== 0 || hit < 0) begin
            errors++; $display("FAIL abort_no_done got done=%0d hit=%0d exp 0/>=0", dones, hit);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL random c=%0d got=%b exp=%b", c, obs, expv);
            end
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 40) == 0);
            tick = ($urandom_range(0, 2) == 0);
            blink_in = $urandom;
            pattern = PLEN'($urandom);
            reps = RBITS'($urandom_range(0, 3));
            gate = $urandom;
        end
        start = 0; abort = 0; tick = 0;
    endtask

    task automatic test_async_reset();
        reps = 2; pattern = 8'hFF; gate = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 0);
            tick = (c >= 2);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== {(SW+3){1'b0}}) begin
            errors++; $display("FAIL async_reset got=%b exp=0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv || busy !== 1'b0) begin
                errors++; $display("FAIL post_reset c=%0d got=%b exp=%b", c, obs, expv);
            end
            tick = $urandom;
        end
        tick = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reps();
        test_wrap();
        test_gate();
        test_abort();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
